// File: rtl/audio_fir_pkg.sv
// rtl/audio_fir_pkg.sv - shared types, widths and helpers for the stereo moving-average stage
package audio_fir_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_LOG2_N = 3;
    localparam int SUM_W      = DEF_DATA_W + DEF_LOG2_N;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_ACC,
        S_WAIT,
        S_PUSH
    } fir_state_e;

    // Divide a running sum by the tap count, rounding toward minus infinity.
    function automatic logic signed [63:0] avg_shift(input logic signed [63:0] sum,
                                                     input int unsigned log2_n);
        return sum >>> log2_n;
    endfunction

endpackage

// File: rtl/audio_fir_avg_channel.sv
// rtl/audio_fir_avg_channel.sv - one channel: circular history, running sum, registered output
module fir_avg_channel
    import audio_fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     acc_en,
    input  logic                     en_avg,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);

    localparam int N   = 1 << LOG2_N;
    localparam int SW  = DATA_W + LOG2_N;

    logic signed [DATA_W-1:0] hist [N];
    logic        [LOG2_N-1:0] ptr;
    logic signed [SW-1:0]     sum;
    logic signed [SW-1:0]     sum_next;

    // The slot under ptr holds the oldest sample, which leaves the window now.
    assign sum_next = sum + SW'(x) - SW'(hist[ptr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            ptr <= '0;
            sum <= '0;
            y   <= '0;
        end else if (acc_en) begin
            hist[ptr] <= x;
            ptr       <= ptr + 1'b1;
            sum       <= sum_next;
            y         <= en_avg ? DATA_W'(avg_shift(64'(sum_next), LOG2_N)) : x;
        end
    end

endmodule

// File: rtl/audio_fir_avg.sv
// rtl/audio_fir_avg.sv - codec pop/filter/push sequencer around two moving-average channels
module audio_fir_avg
    import audio_fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              en_filter,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right
);

    fir_state_e        state;
    logic [DATA_W-1:0] x_left;
    logic [DATA_W-1:0] x_right;
    logic              en_lat;
    logic              acc_en;

    assign acc_en = (state == S_ACC);

    // Strobes are registered, so each is raised on entry to its state.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            read    <= 1'b0;
            write   <= 1'b0;
            x_left  <= '0;
            x_right <= '0;
            en_lat  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (read_ready) begin
                        x_left  <= readdata_left;
                        x_right <= readdata_right;
                        en_lat  <= en_filter;
                        read    <= 1'b1;
                        state   <= S_POP;
                    end
                end
                S_POP: begin
                    read  <= 1'b0;
                    state <= S_ACC;
                end
                S_ACC: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (write_ready) begin
                        write <= 1'b1;
                        state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    write <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    read  <= 1'b0;
                    write <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    fir_avg_channel #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_left (
        .clk    (CLOCK_50),
        .rst_n  (reset_n),
        .acc_en (acc_en),
        .en_avg (en_lat),
        .x      (x_left),
        .y      (writedata_left)
    );

    fir_avg_channel #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_right (
        .clk    (CLOCK_50),
        .rst_n  (reset_n),
        .acc_en (acc_en),
        .en_avg (en_lat),
        .x      (x_right),
        .y      (writedata_right)
    );

endmodule

// File: tb/tb_audio_fir_avg.sv
// tb/tb_audio_fir_avg.sv - randomized self-checking bench for audio_fir_avg
module tb_audio_fir_avg;

    localparam int DW = 24;
    localparam int LN = 3;
    localparam int NT = 1 << LN;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en_filter = 1'b0;
    logic          read_ready = 1'b0;
    logic          write_ready = 1'b0;
    logic [DW-1:0] readdata_left = '0;
    logic [DW-1:0] readdata_right = '0;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;

    int checks = 0;
    int errors = 0;

    longint hist_l[$];
    longint hist_r[$];

    always #10 clk = ~clk;

    audio_fir_avg #(.DATA_W(DW), .LOG2_N(LN)) dut (
        .CLOCK_50        (clk),
        .reset_n         (reset_n),
        .en_filter       (en_filter),
        .read_ready      (read_ready),
        .write_ready     (write_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read            (read),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right)
    );

    // Strobe protocol watch: never coincident, each pulse one cycle wide.
    logic prev_read = 1'b0;
    logic prev_write = 1'b0;
    always @(negedge clk) begin
        if (reset_n && (read || write)) begin
            checks++;
            if ((read && write) || (read && prev_read) || (write && prev_write)) begin
                errors++;
                $display("FAIL strobe_protocol read=%0b write=%0b prev_read=%0b prev_write=%0b required single non-overlapping pulses",
                         read, write, prev_read, prev_write);
            end
        end
        prev_read  = reset_n && read;
        prev_write = reset_n && write;
    end

    // Reference: output is the mean of the last N inputs (zeros before start), floored.
    function automatic longint window_sum(input longint q[$]);
        longint s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic model(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic en,
                         output logic [DW-1:0] el, output logic [DW-1:0] er);
        longint sl, sr;
        hist_l.push_back(longint'($signed(l)));
        hist_r.push_back(longint'($signed(r)));
        if (hist_l.size() > NT) void'(hist_l.pop_front());
        if (hist_r.size() > NT) void'(hist_r.pop_front());
        sl = window_sum(hist_l);
        sr = window_sum(hist_r);
        el = en ? DW'(sl >>> LN) : l;
        er = en ? DW'(sr >>> LN) : r;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        read_ready  = 1'b0;
        write_ready = 1'b0;
        reset_n     = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        hist_l.delete();
        hist_r.delete();
    endtask

    // One full codec transaction; returns what the DUT wrote.
    task automatic xfer(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic en,
                        output logic [DW-1:0] ol, output logic [DW-1:0] orr);
        int k;
        @(negedge clk);
        readdata_left  = l;
        readdata_right = r;
        en_filter      = en;
        read_ready     = 1'b1;
        write_ready    = 1'b1;
        k = 0;
        while (!read && k < 20) begin
            @(negedge clk);
            k++;
        end
        read_ready = 1'b0;
        if (!read) begin
            errors++;
            $display("FAIL read_timeout read=%0b required 1 within 20 cycles", read);
        end
        k = 0;
        while (!write && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!write) begin
            errors++;
            $display("FAIL write_timeout write=%0b required 1 within 20 cycles", write);
        end
        ol  = writedata_left;
        orr = writedata_right;
    endtask

    task automatic test_reset();
        checks++;
        if ({read, write, writedata_left, writedata_right} !== '0) begin
            errors++;
            $display("FAIL reset_outputs read=%0b write=%0b wl=%h wr=%h required all 0",
                     read, write, writedata_left, writedata_right);
        end
    endtask

    task automatic test_step(input string name, input logic [DW-1:0] v, input int count);
        logic [DW-1:0] ol, orr, el, er;
        for (int i = 0; i < count; i++) begin
            xfer(v, v, 1'b1, ol, orr);
            model(v, v, 1'b1, el, er);
            checks++;
            if (ol !== el || orr !== er) begin
                errors++;
                $display("FAIL %s[%0d] got l=%h r=%h required l=%h r=%h", name, i, ol, orr, el, er);
            end
        end
    endtask

    task automatic test_independence();
        logic [DW-1:0] ol, orr, el, er;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            xfer(24'h000800, 24'h000000, 1'b1, ol, orr);
            model(24'h000800, 24'h000000, 1'b1, el, er);
            checks++;
            if (ol !== el || orr !== 24'h0) begin
                errors++;
                $display("FAIL independence[%0d] got l=%h r=%h required l=%h r=000000", i, ol, orr, el);
            end
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] seq [4];
        logic [DW-1:0] ol, orr, el, er, v, w;
        logic          en;
        seq[0] = 24'h123456; seq[1] = 24'h7FFFFF; seq[2] = 24'h800000; seq[3] = 24'h000000;
        for (int i = 0; i < 4; i++) begin
            en = (i == 3);
            xfer(seq[i], seq[i], en, ol, orr);
            model(seq[i], seq[i], en, el, er);
            checks++;
            if (ol !== el || orr !== er || (!en && ol !== seq[i])) begin
                errors++;
                $display("FAIL bypass[%0d] got l=%h r=%h required l=%h r=%h", i, ol, orr, el, er);
            end
        end
        for (int i = 0; i < 24; i++) begin
            v  = DW'($urandom);
            w  = DW'($urandom);
            en = 1'($urandom_range(0, 1));
            xfer(v, w, en, ol, orr);
            model(v, w, en, el, er);
            checks++;
            if (ol !== el || orr !== er) begin
                errors++;
                $display("FAIL random[%0d] en=%0b got l=%h r=%h required l=%h r=%h", i, en, ol, orr, el, er);
            end
        end
    endtask

    task automatic test_handshake();
        logic [DW-1:0] v, el, er;
        int            k;
        bit            quiet;
        v = DW'($urandom_range(0, 24'h3FFFFF));
        @(negedge clk);
        readdata_left = v; readdata_right = v; en_filter = 1'b1;
        read_ready = 1'b1; write_ready = 1'b0;
        k = 0;
        while (!read && k < 20) begin @(negedge clk); k++; end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (read || write) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL stall_quiet got strobe during stall required read=0 write=0");
        end
        write_ready = 1'b1;
        k = 0;
        while (!write && k < 20) begin @(negedge clk); k++; end
        model(v, v, 1'b1, el, er);
        checks++;
        if (!write || writedata_left !== el || writedata_right !== er) begin
            errors++;
            $display("FAIL stall_release write=%0b l=%h r=%h required write=1 l=%h r=%h",
                     write, writedata_left, writedata_right, el, er);
        end
        write_ready = 1'b0;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            k++;
            if (read) break;
        end
        checks++;
        if (!read || k != 2) begin
            errors++;
            $display("FAIL next_read_gap cycles=%0d read=%0b required 2 cycles", k, read);
        end
        read_ready  = 1'b0;
        write_ready = 1'b1;
        k = 0;
        while (!write && k < 20) begin @(negedge clk); k++; end
        model(v, v, 1'b1, el, er);
        checks++;
        if (!write || writedata_left !== el) begin
            errors++;
            $display("FAIL second_push write=%0b l=%h required write=1 l=%h", write, writedata_left, el);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] ol, orr, v, exp_v, el, er;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            v     = (i == 0) ? 24'h000800 : 24'h000000;
            exp_v = (i < NT) ? 24'h000100 : 24'h000000;
            xfer(v, v, 1'b1, ol, orr);
            model(v, v, 1'b1, el, er);
            checks++;
            if (ol !== exp_v || orr !== exp_v) begin
                errors++;
                $display("FAIL wrap[%0d] got l=%h r=%h required %h", i, ol, orr, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] ol, orr, el, er;
        int            k;
        for (int i = 0; i < 3; i++) xfer(24'h000800, 24'h000800, 1'b1, ol, orr);
        @(negedge clk);
        read_ready = 1'b1; write_ready = 1'b0;
        k = 0;
        while (!read && k < 20) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #4;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({read, write, writedata_left, writedata_right} !== '0) begin
            errors++;
            $display("FAIL async_reset read=%0b write=%0b l=%h r=%h required all 0",
                     read, write, writedata_left, writedata_right);
        end
        read_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        hist_l.delete();
        hist_r.delete();
        for (int i = 0; i < NT; i++) begin
            xfer(24'h000800, 24'h000800, 1'b1, ol, orr);
            model(24'h000800, 24'h000800, 1'b1, el, er);
            checks++;
            if (ol !== DW'((i + 1) * 24'h100) || ol !== el || orr !== er) begin
                errors++;
                $display("FAIL post_reset_step[%0d] got l=%h r=%h required %h", i, ol, orr, el);
            end
        end
    endtask

    initial begin
        #35;
        test_reset();
        reset_n = 1'b1;
        test_step("step", 24'h000800, 11);
        apply_reset();
        test_step("negative", 24'hFFF800, 10);
        test_independence();
        test_bypass();
        test_handshake();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
